// File: rtl/rpsc_card7_status_reader_pkg.sv
// Shared definitions for the Card 7 status reader.
// - ff_chan_t   : FF channel index on card_la/card_out (bit i = FF(i+1)).
// - FRAME_HDR   : first byte of every status frame.
// - FRAME_BYTES : bytes per status frame.
// - tx_state_t  : per-byte UART transmitter state.
// - lowest_set  : index of the lowest set bit of an 8-bit vector.
package rpsc_card7_status_reader_pkg;

  typedef enum logic [2:0] {
    FF1_EMERGENCY = 3'd0,
    FF2_CH2       = 3'd1,
    FF3_CH3       = 3'd2,
    FF4_CH4       = 3'd3,
    FF5_CH5       = 3'd4,
    FF6_CH6       = 3'd5,
    FF7_CH7       = 3'd6,
    FF8_GR_SW     = 3'd7
  } ff_chan_t;

  localparam logic [7:0]  FRAME_HDR   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Scans from the top down so the last hit is the lowest index.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rpsc_card7_status_reader_if.sv
// Card-side bundle of the Card 7 status reader.
// master : drives the card lines and the operator acknowledge, observes the outputs.
// slave  : the reader itself.
//   card_la[7:0], card_out[7:0] : alarm / interlock lines (asynchronous)
//   first_up_clr                : operator acknowledge pulse
//   tx_serial, tx_busy          : UART line and frame-in-progress flag
//   first_up_valid, first_up_idx: latched first-up fault
interface rpsc_card7_status_reader_if;
  logic [7:0] card_la;
  logic [7:0] card_out;
  logic       first_up_clr;
  logic       tx_serial;
  logic       tx_busy;
  logic       first_up_valid;
  logic [2:0] first_up_idx;

  modport master (
    output card_la,
    output card_out,
    output first_up_clr,
    input  tx_serial,
    input  tx_busy,
    input  first_up_valid,
    input  first_up_idx
  );

  modport slave (
    input  card_la,
    input  card_out,
    input  first_up_clr,
    output tx_serial,
    output tx_busy,
    output first_up_valid,
    output first_up_idx
  );
endinterface

// File: rtl/rpsc_card7_status_reader_uart_tx_byte.sv
// Single-byte UART 8N1 transmitter (LSB first, idle high).
//   clk, reset : clock and synchronous active-high reset
//   load, data : byte to send; taken only while ready is high
//   ready      : idle, or in the final cycle of a stop bit (allows gapless next byte)
//   busy       : any state other than IDLE
//   serial     : registered line output
module rpsc_card7_status_reader_uart_tx_byte
  import rpsc_card7_status_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       serial
);
  localparam int unsigned    TmW     = $clog2(CLK_DIV);
  localparam logic [TmW-1:0] BitLast = TmW'(CLK_DIV - 1);

  tx_state_t      state_q, state_d;
  logic [TmW-1:0] tm_q, tm_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           serial_q, serial_d;
  logic           bit_end;

  assign bit_end = (tm_q == BitLast);
  assign busy    = (state_q != IDLE);
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign serial  = serial_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tm_d    = (state_q == IDLE || bit_end) ? '0 : tm_q + TmW'(1);
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          sh_d    = data;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            state_d = START;
            sh_d    = data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value follows the next state so serial_q lines up with state_q.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = sh_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tm_q     <= '0;
      bit_q    <= 3'd0;
      sh_q     <= 8'd0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tm_q     <= tm_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: rtl/rpsc_card7_status_reader.sv
// Card 7 status reader: synchronizes and debounces the 8 LA and 8 OUT lines, latches the
// first-up LA fault and reports {A5, LA, OUT, seq/first-up} as a 4-byte UART frame on
// every debounced change and on a periodic idle refresh.
//   clk, reset : clock and synchronous active-high reset
//   bus        : card lines, acknowledge, UART line, busy and first-up outputs
module rpsc_card7_status_reader
  import rpsc_card7_status_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 868,
  parameter int unsigned DEBOUNCE = 1000,
  parameter int unsigned REFRESH  = 10_000_000
) (
  input logic                         clk,
  input logic                         reset,
  rpsc_card7_status_reader_if.slave   bus
);
  localparam int unsigned    DbW    = $clog2(DEBOUNCE + 1);
  localparam int unsigned    RfW    = $clog2(REFRESH + 1);
  localparam int unsigned    IdxW   = $clog2(FRAME_BYTES);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [RfW-1:0] RfLast = RfW'(REFRESH - 1);

  logic [15:0]     sync1_q, sync2_q, cand_q, db_q, sent_q;
  logic [DbW-1:0]  db_cnt_q;
  logic [7:0]      db_la, db_out, la_prev_q, rise;
  logic            fu_valid_q, fu_valid_d;
  logic [2:0]      fu_idx_q, fu_idx_d;
  logic [RfW-1:0]  rf_cnt_q;
  logic [3:0]      seq_q;
  logic            pending_q;
  logic [IdxW-1:0] byte_idx_q;
  logic [23:0]     frame_q;
  logic            change, refresh, launch, next_byte;
  logic            load, ready, busy, serial;
  logic [7:0]      load_data;

  assign db_la  = db_q[7:0];
  assign db_out = db_q[15:8];
  assign rise   = db_la & ~la_prev_q;

  // Input synchronizer and shared-counter debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      db_cnt_q <= '0;
      db_q     <= '0;
    end else begin
      sync1_q <= {bus.card_out, bus.card_la};
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q   <= sync2_q;
        db_cnt_q <= '0;
      end else if (db_cnt_q != DbLast) begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end else begin
        db_q <= cand_q;
      end
    end
  end

  // First-up latch: a rise coinciding with the acknowledge wins over the clear.
  always_comb begin
    fu_valid_d = fu_valid_q;
    fu_idx_d   = fu_idx_q;
    if ((rise != 8'd0) && (!fu_valid_q || bus.first_up_clr)) begin
      fu_valid_d = 1'b1;
      fu_idx_d   = lowest_set(rise);
    end else if (bus.first_up_clr) begin
      fu_valid_d = 1'b0;
      fu_idx_d   = 3'd0;
    end
  end

  assign change    = (db_q != sent_q);
  assign refresh   = (rf_cnt_q == RfLast);
  assign launch    = !busy && (change || refresh || pending_q);
  // byte_idx_q == 0 while a frame is running means byte3 is already on the line.
  assign next_byte = ready && busy && (byte_idx_q != '0);
  assign load      = launch || next_byte;

  always_comb begin
    load_data = FRAME_HDR;
    if (!launch) begin
      case (byte_idx_q)
        IdxW'(1): load_data = frame_q[7:0];
        IdxW'(2): load_data = frame_q[15:8];
        IdxW'(3): load_data = frame_q[23:16];
        default:  load_data = FRAME_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      la_prev_q  <= '0;
      fu_valid_q <= 1'b0;
      fu_idx_q   <= 3'd0;
      sent_q     <= '0;
      pending_q  <= 1'b0;
      seq_q      <= 4'd0;
      rf_cnt_q   <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
    end else begin
      la_prev_q  <= db_la;
      fu_valid_q <= fu_valid_d;
      fu_idx_q   <= fu_idx_d;
      if (launch) begin
        // Snapshot uses the first-up next state so a fault that caused this frame is in it.
        frame_q    <= {seq_q, fu_valid_d, fu_idx_d, db_out, db_la};
        sent_q     <= db_q;
        pending_q  <= 1'b0;
        seq_q      <= seq_q + 4'd1;
        rf_cnt_q   <= '0;
        byte_idx_q <= IdxW'(1);
      end else begin
        if (busy && (change || refresh)) pending_q <= 1'b1;
        if (!busy) rf_cnt_q <= rf_cnt_q + RfW'(1);
        // Wraps to 0 after byte3 is loaded, which ends the frame.
        if (next_byte) byte_idx_q <= byte_idx_q + IdxW'(1);
      end
    end
  end

  rpsc_card7_status_reader_uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data   (load_data),
    .ready  (ready),
    .busy   (busy),
    .serial (serial)
  );

  assign bus.tx_serial      = serial;
  assign bus.tx_busy        = busy;
  assign bus.first_up_valid = fu_valid_q;
  assign bus.first_up_idx   = fu_idx_q;

endmodule

// File: tb/tb_rpsc_card7_status_reader.sv
// Self-checking bench for rpsc_card7_status_reader (CLK_DIV=4, DEBOUNCE=8, REFRESH=1000).
module tb_rpsc_card7_status_reader;
  localparam int TB_DIV = 4;
  localparam int TB_DB  = 8;
  localparam int TB_RF  = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rpsc_card7_status_reader_if bus ();

  rpsc_card7_status_reader #(
    .CLK_DIV  (TB_DIV),
    .DEBOUNCE (TB_DB),
    .REFRESH  (TB_RF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] frames_q[$];
  int          busy_len_q[$];
  int          gap_q[$];
  int          busy_rises = 0;
  int          frame_errs = 0;

  // UART receiver: decodes bytes mid-bit and groups them into 4-byte frames.
  initial begin : rx_mon
    bit         on;
    int         t;
    logic [7:0] sh;
    logic [7:0] bytes[$];
    on = 1'b0;
    t  = 0;
    sh = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        on = 1'b0;
        bytes.delete();
      end else if (!on) begin
        if (bus.tx_serial === 1'b0) begin
          on = 1'b1;
          t  = 0;
        end
      end else begin
        t++;
        if ((t % TB_DIV == TB_DIV / 2) && t > TB_DIV && t < 9 * TB_DIV)
          sh = {bus.tx_serial, sh[7:1]};
        if (t == 9 * TB_DIV + TB_DIV / 2) begin
          on = 1'b0;
          if (bus.tx_serial !== 1'b1) frame_errs++;
          bytes.push_back(sh);
          if (bytes.size() == 4) begin
            frames_q.push_back({bytes[0], bytes[1], bytes[2], bytes[3]});
            bytes.delete();
          end
        end
      end
    end
  end

  // Busy monitor: busy run lengths and idle gaps between frames.
  initial begin : busy_mon
    int run;
    int low;
    run = 0;
    low = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        low = 0;
      end else if (bus.tx_busy === 1'b1) begin
        if (run == 0) begin
          busy_rises++;
          if (busy_len_q.size() > 0) gap_q.push_back(low);
        end
        run++;
        low = 0;
      end else begin
        if (run != 0) busy_len_q.push_back(run);
        run = 0;
        low++;
      end
    end
  end

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    frames_q.delete();
    busy_len_q.delete();
    gap_q.delete();
    busy_rises = 0;
    frame_errs = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset            = 1'b1;
    bus.card_la      = 8'd0;
    bus.card_out     = 8'd0;
    bus.first_up_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic wait_frames(input int n, input int bound);
    for (int i = 0; i < bound && frames_q.size() < n; i++) cycles(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.tx_serial, bus.tx_busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_tx: got serial/busy=%b required 10", {bus.tx_serial, bus.tx_busy});
    end
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_first_up: got %b required 0000", {bus.first_up_valid, bus.first_up_idx});
    end
  endtask

  task automatic test_refresh();
    do_reset();
    cycles(900);
    checks++;
    if (busy_rises != 0) begin
      failures++;
      $display("FAIL refresh_quiet: got %0d frame starts required 0", busy_rises);
    end
    wait_frames(1, 400);
    checks++;
    if (frames_q.size() != 1) begin
      failures++;
      $display("FAIL refresh_first: got %0d frames required 1", frames_q.size());
    end else if (frames_q[0] !== 32'hA500_0000) begin
      failures++;
      $display("FAIL refresh_first: got %h required a5000000", frames_q[0]);
    end
    wait_frames(2, 1400);
    checks++;
    if (frames_q.size() < 2) begin
      failures++;
      $display("FAIL refresh_second: got %0d frames required 2", frames_q.size());
    end else if (frames_q[1] !== 32'hA500_0010) begin
      failures++;
      $display("FAIL refresh_second: got %h required a5000010", frames_q[1]);
    end
    checks++;
    if (busy_len_q.size() < 1 || busy_len_q[0] != 40 * TB_DIV) begin
      failures++;
      $display("FAIL refresh_busy_len: got %0d runs, first %0d required %0d", busy_len_q.size(),
               (busy_len_q.size() > 0) ? busy_len_q[0] : -1, 40 * TB_DIV);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    bus.card_la = 8'h04;
    cycles(5);
    bus.card_la = 8'h00;
    cycles(30);
    checks++;
    if (busy_rises != 0 || bus.first_up_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: got starts=%0d valid=%b required 0 0", busy_rises,
               bus.first_up_valid);
    end
    bus.card_la = 8'h04;
    cycles(20);
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b1010) begin
      failures++;
      $display("FAIL debounce_first_up: got %b required 1010", {bus.first_up_valid, bus.first_up_idx});
    end
    wait_frames(1, 300);
    checks++;
    if (frames_q.size() != 1) begin
      failures++;
      $display("FAIL debounce_frame: got %0d frames required 1", frames_q.size());
    end else if (frames_q[0] !== 32'hA504_000A) begin
      failures++;
      $display("FAIL debounce_frame: got %h required a504000a", frames_q[0]);
    end
  endtask

  task automatic test_first_up_priority();
    do_reset();
    bus.card_la = 8'h90;
    // Accepted at input edge + 2 + DEBOUNCE; first-up and launch one cycle later.
    cycles(2 + TB_DB + 1);
    checks++;
    if ({bus.first_up_valid, bus.tx_busy} !== 2'b00) begin
      failures++;
      $display("FAIL latency_early: got valid/busy=%b required 00", {bus.first_up_valid, bus.tx_busy});
    end
    cycles(1);
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b1100) begin
      failures++;
      $display("FAIL priority_idx: got %b required 1100", {bus.first_up_valid, bus.first_up_idx});
    end
    checks++;
    if ({bus.tx_busy, bus.tx_serial} !== 2'b10) begin
      failures++;
      $display("FAIL launch_start_bit: got busy/serial=%b required 10", {bus.tx_busy, bus.tx_serial});
    end
    bus.card_la = 8'h91;
    cycles(20);
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b1100) begin
      failures++;
      $display("FAIL later_rise_ignored: got %b required 1100", {bus.first_up_valid, bus.first_up_idx});
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    bus.card_la = 8'h01;
    cycles(15);
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b1000) begin
      failures++;
      $display("FAIL clr_setup: got %b required 1000", {bus.first_up_valid, bus.first_up_idx});
    end
    bus.card_la = 8'h03;
    cycles(2 + TB_DB + 1);
    bus.first_up_clr = 1'b1;   // same cycle as the bit-1 rise
    cycles(1);
    bus.first_up_clr = 1'b0;
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b1001) begin
      failures++;
      $display("FAIL clr_with_rise: got %b required 1001", {bus.first_up_valid, bus.first_up_idx});
    end
    bus.first_up_clr = 1'b1;
    cycles(1);
    bus.first_up_clr = 1'b0;
    checks++;
    if ({bus.first_up_valid, bus.first_up_idx} !== 4'b0000) begin
      failures++;
      $display("FAIL clr_no_rise: got %b required 0000", {bus.first_up_valid, bus.first_up_idx});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.card_out = 8'h01;
    for (int i = 0; i < 40 && bus.tx_busy !== 1'b1; i++) cycles(1);
    cycles(20);
    bus.card_out = 8'hFF;
    cycles(20);
    bus.card_out = 8'hFE;
    wait_frames(2, 600);
    cycles(100);
    checks++;
    if (frames_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d frames required 2", frames_q.size());
    end else begin
      checks++;
      if (frames_q[0] !== 32'hA500_0100) begin
        failures++;
        $display("FAIL b2b_first: got %h required a5000100", frames_q[0]);
      end
      checks++;
      if (frames_q[1] !== 32'hA500_FE10) begin
        failures++;
        $display("FAIL b2b_second: got %h required a500fe10", frames_q[1]);
      end
    end
    checks++;
    if (busy_len_q.size() != 2 || busy_len_q[0] != 40 * TB_DIV || busy_len_q[1] != 40 * TB_DIV) begin
      failures++;
      $display("FAIL b2b_busy_len: got %0d runs (%0d,%0d) required 2 of %0d", busy_len_q.size(),
               (busy_len_q.size() > 0) ? busy_len_q[0] : -1,
               (busy_len_q.size() > 1) ? busy_len_q[1] : -1, 40 * TB_DIV);
    end
    checks++;
    if (gap_q.size() != 1 || gap_q[0] < 1) begin
      failures++;
      $display("FAIL b2b_gap: got %0d gaps, first %0d required one gap >= 1", gap_q.size(),
               (gap_q.size() > 0) ? gap_q[0] : -1);
    end
    checks++;
    if (frame_errs != 0) begin
      failures++;
      $display("FAIL b2b_stop_bits: got %0d bad stop bits required 0", frame_errs);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.card_out = 8'h3C;
    for (int i = 0; i < 40 && bus.tx_busy !== 1'b1; i++) cycles(1);
    cycles(90);   // inside the data bits of byte2
    reset        = 1'b1;
    bus.card_out = 8'h00;
    cycles(1);
    checks++;
    if ({bus.tx_serial, bus.tx_busy} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset_line: got serial/busy=%b required 10", {bus.tx_serial, bus.tx_busy});
    end
    reset = 1'b0;
    clear_mon();
    cycles(300);
    checks++;
    if (busy_rises != 0 || frames_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_no_pending: got starts=%0d frames=%0d required 0 0", busy_rises,
               frames_q.size());
    end
    wait_frames(1, 1300);
    checks++;
    if (frames_q.size() != 1) begin
      failures++;
      $display("FAIL mid_reset_seq: got %0d frames required 1", frames_q.size());
    end else if (frames_q[0] !== 32'hA500_0000) begin
      failures++;
      $display("FAIL mid_reset_seq: got %h required a5000000", frames_q[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] model_db;
    logic [15:0] nv;
    logic [7:0]  rise;
    bit          model_valid;
    logic [2:0]  model_idx;
    logic [3:0]  model_seq;
    bit          prev_same;
    logic [31:0] exp_q[$];
    do_reset();
    model_db    = 16'd0;
    model_valid = 1'b0;
    model_idx   = 3'd0;
    model_seq   = 4'd0;
    prev_same   = 1'b0;
    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.first_up_clr = 1'b1;
        cycles(1);
        bus.first_up_clr = 1'b0;
        model_valid = 1'b0;
        model_idx   = 3'd0;
      end
      // Never two unchanged steps in a row, so no refresh frame can slip in.
      if (!prev_same && $urandom_range(0, 3) == 0) nv = model_db;
      else nv = 16'($urandom);
      if (prev_same && nv == model_db) nv = nv ^ 16'h0001;
      if ($urandom_range(0, 1) == 1) begin
        bus.card_la  = 8'($urandom);
        bus.card_out = 8'($urandom);
        cycles($urandom_range(1, 5));
      end
      bus.card_la  = nv[7:0];
      bus.card_out = nv[15:8];
      prev_same = (nv == model_db);
      if (nv != model_db) begin
        rise = nv[7:0] & ~model_db[7:0];
        if (!model_valid && rise != 8'd0) begin
          model_valid = 1'b1;
          model_idx   = lowest(rise);
        end
        exp_q.push_back({8'hA5, nv[7:0], nv[15:8], model_seq, model_valid, model_idx});
        model_seq = model_seq + 4'd1;
      end
      model_db = nv;
      cycles(260);
      checks++;
      if ({bus.first_up_valid, bus.first_up_idx} !== {model_valid, model_idx}) begin
        failures++;
        $display("FAIL rand_first_up step %0d: got %b required %b", s,
                 {bus.first_up_valid, bus.first_up_idx}, {model_valid, model_idx});
      end
    end
    checks++;
    if (frames_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_frame_count: got %0d required %0d", frames_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < frames_q.size(); i++) begin
      checks++;
      if (frames_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_frame %0d: got %h required %h", i, frames_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.card_la      = 8'd0;
    bus.card_out     = 8'd0;
    bus.first_up_clr = 1'b0;
    test_reset();
    test_refresh();
    test_debounce();
    test_first_up_priority();
    test_clr_collision();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
